edge_event_encoder: RTL and testbench
=====================================

# edge_event_encoder

Parametrised successor to the fixed 9-input level priority decoder. It performs true per-channel edge detection with a runtime-selectable edge mode, and holds one sticky pending bit per channel so no event is lost while the consumer is busy. Events are delivered one at a time as a channel index over a valid/ready handshake, with fixed-priority or round-robin arbitration. It sits between the scene-trigger sources (timers, beat/audio strobes, button inputs) and the VGA demoscene sequencer.

## Interface
Parameters:
- `N_CH`, 9: number of input channels (2..32).
- `IDX_W`, `$clog2(N_CH)`: event index width; derived, never overridden.
- `SYNC_STAGES`, 2: input synchroniser depth (0 = inputs already in `clk` domain).
- `ARB_RR`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `in_signals`  in  N_CH  raw event sources.
- `edge_mode`  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- `event_valid`  out  1  an event index is presented.
- `event_num`  out  IDX_W  channel index of the presented event.
- `event_ready`  in  1  consumer accepts the event when high together with `event_valid`.
- `pending`  out  N_CH  sticky per-channel pending bits (status).
- `overrun`  out  N_CH  sticky per-channel overrun flags.
- `overrun_clr`  in  N_CH  write-1-to-clear for `overrun`.

## Operation
- Reset (async assert, sync release): synchroniser stages, previous-sample register, `pending`, `overrun`, `event_valid`, `event_num`, the RR pointer and `armed` all reset to 0.
- `armed`: the first clock after reset release only loads the previous-sample register. No edges are detected on that clock, so levels already high at reset are not events.
- Edge detection on the synchronised sample `s` against previous `p`: rise = s & ~p; fall = ~s & p; the mode selects which counts; mode 00 never detects.
- Mode change takes effect on the next clock. It does not clear `pending`.
- A detected edge on channel i sets `pending[i]`.
  - If `pending[i]` is already 1 and is not being cleared this cycle, `overrun[i]` is set instead (the event count is lost, one event is kept).
- Output register is empty when `event_valid`=0, or is being accepted (`event_valid & event_ready`).
  - When empty and any `pending` bit is set, the arbiter picks channel g, loads `event_num`=g, sets `event_valid`=1 and clears `pending[g]`.
  - If the same cycle detects a new edge on g, the set wins: `pending[g]` stays 1 and no overrun is flagged.
- The arbiter samples the registered `pending` value from before this edge, not newly detected edges.
- Fixed priority: lowest set index. Round-robin: the first set index strictly after the last granted index, wrapping modulo N_CH; the pointer updates only on a grant.
- `event_valid`/`event_num` are held stable until accepted. Accept with nothing pending gives `event_valid`=0 on the next cycle.
- `overrun_clr[i]` clears `overrun[i]`. A simultaneous new overrun on i wins (the flag stays set).

## Timing
- Input-to-detect latency: SYNC_STAGES clocks of synchroniser, then detection at the next edge. `pending` is visible 1 clock after detection. `event_valid` is visible 1 clock after `pending`.
- With SYNC_STAGES=0: input changes before edge k, `pending` is set after k, `event_valid` after k+1.
- Sustained throughput: one event per clock while `event_ready`=1.
- `event_ready` has no combinational path to any output. All outputs are registered.

## Structure
- Shared package `edge_event_pkg`:
  - mode constants `EM_OFF`, `EM_RISE`, `EM_FALL`, `EM_BOTH`;
  - typedef for the 2-bit mode field.
- Sub-module `edge_arbiter`: combinational; inputs are the pending vector and the RR pointer; outputs are grant-valid and grant index. It implements both modes by rotate → lowest-index find → un-rotate.
- Synchroniser is an inline generate loop; no separate module.

## Test plan
- Reset with `in_signals`[3]=1, all modes 01: no event after release. Drop ch3 then raise it: exactly one event, `event_num`=3.
- Mode 10 on ch0, mode 11 on ch5, pulse both for one clock: ch0 reports on the fall, ch5 reports twice (rise and fall). Mode 00 channels never report.
- Fixed priority, edges on ch1, ch4, ch8 in the same clock, `event_ready`=1: `event_num` sequence 1, 4, 8 on consecutive clocks, then `event_valid`=0.
- ARB_RR=1, ch2 and ch6 retriggered continuously: grants alternate 2, 6, 2, 6. Under fixed priority ch2 starves ch6.
- `event_ready`=0, three rising edges on ch7: one pending, `overrun`[7]=1, one event delivered when ready rises. `overrun_clr`[7] clears the flag.
- Assert `reset` mid-stream with `event_valid`=1 and pending bits set: all outputs are 0 immediately (asynchronously), and there are no spurious events after release.

Source files
------------

// File: rtl/edge_event_pkg.sv
// edge_event_pkg: shared mode encodings for the edge event encoder.
// Each channel has a 2-bit field that selects which edges it reports.
package edge_event_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EM_OFF  = 2'b00;
    localparam edge_mode_t EM_RISE = 2'b01;
    localparam edge_mode_t EM_FALL = 2'b10;
    localparam edge_mode_t EM_BOTH = 2'b11;

endpackage

// File: rtl/edge_arbiter.sv
// edge_arbiter: combinational pending-vector arbiter.
// Rotates to the search start, finds the lowest set bit, then un-rotates.
module edge_arbiter
    import edge_event_pkg::*;
#(
    parameter int N_CH   = 9,
    parameter int IDX_W  = $clog2(N_CH),
    parameter bit ARB_RR = 1'b0
) (
    input  logic [N_CH-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] start;
    logic [N_CH-1:0]  rot;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   sum;

    // Search starts just after the last grant in round-robin, else at 0.
    always_comb begin
        start = '0;
        if (ARB_RR && (rr_ptr != IDX_W'(N_CH - 1))) begin
            start = rr_ptr + IDX_W'(1);
        end
    end

    // Rotate, pick the lowest set bit, map back to a channel index.
    always_comb begin
        rot         = N_CH'({pending, pending} >> start);
        grant_valid = 1'b0;
        sel         = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_valid = 1'b1;
                sel         = IDX_W'(j);
            end
        end
        sum = {1'b0, sel} + {1'b0, start};
        if (sum >= (IDX_W + 1)'(N_CH)) begin
            sum = sum - (IDX_W + 1)'(N_CH);
        end
        grant_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/edge_event_encoder.sv
// edge_event_encoder: per-channel edge detector with sticky pending bits.
// Events leave one at a time as a channel index over valid/ready.
module edge_event_encoder
    import edge_event_pkg::*;
#(
    parameter int N_CH        = 9,
    parameter int IDX_W       = $clog2(N_CH),
    parameter int SYNC_STAGES = 2,
    parameter int ARB_RR      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   in_signals,
    input  logic [2*N_CH-1:0] edge_mode,
    output logic              event_valid,
    output logic [IDX_W-1:0]  event_num,
    input  logic              event_ready,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overrun,
    input  logic [N_CH-1:0]   overrun_clr
);

    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  p;
    logic             armed;
    logic [N_CH-1:0]  det;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic             take;
    logic [N_CH-1:0]  clr_vec;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = in_signals;
    end else begin : g_sync
        logic [N_CH-1:0] q [SYNC_STAGES];

        // Shift raw inputs through the synchroniser chain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) q[k] <= '0;
            end else begin
                q[0] <= in_signals;
                for (int k = 1; k < SYNC_STAGES; k++) q[k] <= q[k-1];
            end
        end

        assign s = q[SYNC_STAGES-1];
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_det
        edge_mode_t m;
        logic       rise_en;
        logic       fall_en;
        assign m       = edge_mode[2*i+1:2*i];
        assign rise_en = (m == EM_RISE) || (m == EM_BOTH);
        assign fall_en = (m == EM_FALL) || (m == EM_BOTH);
        assign det[i]  = armed & ((rise_en & s[i] & ~p[i]) |
                                  (fall_en & ~s[i] & p[i]));
    end

    edge_arbiter #(
        .N_CH   (N_CH),
        .IDX_W  (IDX_W),
        .ARB_RR (ARB_RR != 0)
    ) u_arb (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Grant when the output slot is free or draining this cycle.
    always_comb begin
        take    = (~event_valid | event_ready) & grant_valid;
        clr_vec = '0;
        if (take) clr_vec[grant_idx] = 1'b1;
    end

    // Previous sample; first clock after reset only primes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p     <= '0;
            armed <= 1'b0;
        end else begin
            p     <= s;
            armed <= 1'b1;
        end
    end

    // Sticky pending and overrun; a new edge beats grant and clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | det;
            overrun <= (overrun & ~overrun_clr) |
                       (det & pending & ~clr_vec);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_valid <= 1'b0;
            event_num   <= '0;
            rr_ptr      <= '0;
        end else if (take) begin
            event_valid <= 1'b1;
            event_num   <= grant_idx;
            rr_ptr      <= grant_idx;
        end else if (event_ready) begin
            event_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_event_encoder.sv
// tb_edge_event_encoder: directed plus random stimulus against a
// channel-level reference model for three encoder configurations.
module tb_edge_event_encoder;

    localparam int N = 9;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_s;
    logic [N-1:0]   ovc;
    logic [2*N-1:0] mode;
    logic           rdy;

    logic         v0, v1, v2;
    logic [3:0]   n0, n1, n2;
    logic [N-1:0] p0, p1, p2;
    logic [N-1:0] o0, o1, o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_event_encoder #(.N_CH(N), .SYNC_STAGES(0), .ARB_RR(0)) u_fp (
        .clk(clk), .reset(reset), .in_signals(in_s), .edge_mode(mode),
        .event_valid(v0), .event_num(n0), .event_ready(rdy),
        .pending(p0), .overrun(o0), .overrun_clr(ovc)
    );

    edge_event_encoder #(.N_CH(N), .SYNC_STAGES(0), .ARB_RR(1)) u_rr (
        .clk(clk), .reset(reset), .in_signals(in_s), .edge_mode(mode),
        .event_valid(v1), .event_num(n1), .event_ready(rdy),
        .pending(p1), .overrun(o1), .overrun_clr(ovc)
    );

    edge_event_encoder #(.N_CH(N), .SYNC_STAGES(2), .ARB_RR(0)) u_sy (
        .clk(clk), .reset(reset), .in_signals(in_s), .edge_mode(mode),
        .event_valid(v2), .event_num(n2), .event_ready(rdy),
        .pending(p2), .overrun(o2), .overrun_clr(ovc)
    );

    int           m_rr [3] = '{0, 1, 0};
    int           m_sy [3] = '{0, 0, 2};
    bit [N-1:0]   m_sq [3][2];
    bit [N-1:0]   m_prev [3];
    bit           m_armed [3];
    bit [N-1:0]   m_pend [3];
    bit [N-1:0]   m_ovr [3];
    bit           m_val [3];
    int           m_num [3];
    int           m_last [3];
    int           log0 [$];
    int           log1 [$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sq[k][0] = '0;
            m_sq[k][1] = '0;
            m_prev[k]  = '0;
            m_armed[k] = 1'b0;
            m_pend[k]  = '0;
            m_ovr[k]   = '0;
            m_val[k]   = 1'b0;
            m_num[k]   = 0;
            m_last[k]  = 0;
        end
    endtask

    function automatic bit hits(int md, bit s, bit p);
        return (((md & 1) != 0) && s && !p) || (((md & 2) != 0) && !s && p);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit [N-1:0] s;
            bit [N-1:0] det;
            bit [N-1:0] np;
            bit [N-1:0] no;
            int g;
            s = (m_sy[k] == 0) ? in_s : m_sq[k][m_sy[k]-1];
            for (int i = 0; i < N; i++) begin
                int md;
                md = int'((mode >> (2 * i)) & 18'd3);
                det[i] = m_armed[k] && hits(md, s[i], m_prev[k][i]);
            end
            g = -1;
            if (!m_val[k] || rdy) begin
                if (m_rr[k] == 0) begin
                    for (int i = 0; i < N; i++)
                        if (g < 0 && m_pend[k][i]) g = i;
                end else begin
                    for (int j = 1; j <= N; j++) begin
                        int c;
                        c = (m_last[k] + j) % N;
                        if (g < 0 && m_pend[k][c]) g = c;
                    end
                end
            end
            np = m_pend[k];
            no = m_ovr[k] & ~ovc;
            if (g >= 0) np[g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (det[i]) begin
                    if (np[i]) no[i] = 1'b1;
                    np[i] = 1'b1;
                end
            end
            if (g >= 0) begin
                m_val[k]  = 1'b1;
                m_num[k]  = g;
                m_last[k] = g;
            end else if (rdy) begin
                m_val[k] = 1'b0;
            end
            m_pend[k]  = np;
            m_ovr[k]   = no;
            m_sq[k][1] = m_sq[k][0];
            m_sq[k][0] = in_s;
            m_prev[k]  = s;
            m_armed[k] = 1'b1;
        end
    endtask

    task automatic cmp(int k, logic v, logic [3:0] n,
                       logic [N-1:0] p, logic [N-1:0] o);
        check($sformatf("i%0d_valid", k), 32'(v), 32'(m_val[k]));
        check($sformatf("i%0d_num", k), 32'(n), m_num[k]);
        check($sformatf("i%0d_pending", k), 32'(p), 32'(m_pend[k]));
        check($sformatf("i%0d_overrun", k), 32'(o), 32'(m_ovr[k]));
    endtask

    task automatic compare_all();
        cmp(0, v0, n0, p0, o0);
        cmp(1, v1, n1, p1, o1);
        cmp(2, v2, n2, p2, o2);
    endtask

    task automatic cycle();
        if (v0 && rdy) log0.push_back(int'(n0));
        if (v1 && rdy) log1.push_back(int'(n1));
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    initial begin
        int six_cnt;

        // Reset with ch3 already high, all channels rising.
        reset = 1'b0;
        in_s  = 9'h008;
        mode  = {N{2'b01}};
        rdy   = 1'b1;
        ovc   = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        check("rst_valid", 32'(v0), 0);
        check("rst_pending", 32'(p0), 0);
        reset = 1'b1;
        run(6);
        check("lvl_no_event", log0.size(), 0);
        in_s[3] = 1'b0;
        run(2);
        in_s[3] = 1'b1;
        run(4);
        check("ch3_count", log0.size(), 1);
        check("ch3_num", (log0.size() > 0) ? log0[0] : -1, 3);

        // ch0 falling only, ch5 both edges, others off but toggling.
        mode = '0;
        mode[1:0]   = 2'b10;
        mode[11:10] = 2'b11;
        in_s = '0;
        run(3);
        clear_logs();
        in_s = (N'($urandom) & 9'h1DE) | 9'h021;
        run(1);
        in_s = N'($urandom) & 9'h1DE;
        run(6);
        check("mode_len", log0.size(), 3);
        check("mode_e0", (log0.size() > 0) ? log0[0] : -1, 5);
        check("mode_e1", (log0.size() > 1) ? log0[1] : -1, 0);
        check("mode_e2", (log0.size() > 2) ? log0[2] : -1, 5);

        // Simultaneous edges drain in priority order.
        mode = {N{2'b01}};
        in_s = '0;
        run(3);
        clear_logs();
        in_s = 9'h112;
        run(6);
        check("prio_len", log0.size(), 3);
        check("prio_e0", (log0.size() > 0) ? log0[0] : -1, 1);
        check("prio_e1", (log0.size() > 1) ? log0[1] : -1, 4);
        check("prio_e2", (log0.size() > 2) ? log0[2] : -1, 8);

        // ch2 and ch6 retriggered every clock.
        mode = '0;
        mode[5:4]   = 2'b11;
        mode[13:12] = 2'b11;
        in_s = '0;
        run(3);
        clear_logs();
        repeat (12) begin
            in_s = in_s ^ 9'h044;
            run(1);
        end
        six_cnt = 0;
        foreach (log0[k]) if (log0[k] == 6) six_cnt++;
        check("fp_starve", six_cnt, 0);
        check("rr_len", 32'(log1.size() >= 9), 1);
        for (int k = 0; k < 8; k++) begin
            if (k + 1 < log1.size())
                check("rr_alt", 32'(log1[k] != log1[k+1]), 1);
        end
        mode = '0;
        ovc  = '1;
        run(1);
        ovc = '0;
        run(4);

        // Backpressure with repeated edges on ch7.
        mode[15:14] = 2'b01;
        in_s = '0;
        run(3);
        clear_logs();
        rdy = 1'b0;
        repeat (6) begin
            in_s[7] = ~in_s[7];
            run(1);
        end
        check("ovr7_set", 32'(o0[7]), 1);
        check("pend7_set", 32'(p0[7]), 1);
        check("held_num", 32'(n0), 7);
        ovc[7] = 1'b1;
        run(1);
        ovc = '0;
        check("ovr7_clr", 32'(o0[7]), 0);
        rdy = 1'b1;
        run(4);
        check("ch7_events", log0.size(), 2);

        // Asynchronous reset in the middle of traffic.
        mode = 18'($urandom);
        rdy  = 1'b0;
        repeat (8) begin
            in_s = N'($urandom);
            run(1);
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(v0), 0);
        check("arst_num", 32'(n0), 0);
        check("arst_pending", 32'(p0), 0);
        check("arst_overrun", 32'(o0), 0);
        check("arst_valid_rr", 32'(v1), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(2);
        check("post_rst_pending", 32'(p0), 0);
        check("post_rst_valid", 32'(v0), 0);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            in_s = N'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            ovc  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) mode = 18'($urandom);
            run(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
